// File: rtl/ysyx_23060124_lsu_if.sv
// Memory port between the LSU and the data memory: one request channel
// (valid/ready) and a single-cycle response pulse.
interface ysyx_23060124_lsu_if #(
    parameter int unsigned ISA_WIDTH = 32
);
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ISA_WIDTH-1:0] mem_addr;
    logic                 mem_wen;
    logic [ISA_WIDTH-1:0] mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_resp_valid;
    logic [ISA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_addr,
        output mem_wen,
        output mem_wdata,
        output mem_wstrb,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        input  mem_wen,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_rdata
    );
endinterface

// File: rtl/ysyx_23060124_lsu.sv
// Load/store unit: takes one EXU packet at a time, runs at most one memory
// access, aligns/extends load data and hands a writeback packet to the WBU.
module ysyx_23060124_lsu #(
    parameter int unsigned ISA_WIDTH = 32,
    parameter int unsigned REG_AW    = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ISA_WIDTH-1:0]      in_alu_res,
    input  logic [ISA_WIDTH-1:0]      in_wdata,
    input  logic                      in_is_load,
    input  logic                      in_is_store,
    input  logic [2:0]                in_funct3,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic                      in_rd_wen,
    ysyx_23060124_lsu_if.master       mem,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ISA_WIDTH-1:0]      out_res,
    output logic [REG_AW-1:0]         out_rd,
    output logic                      out_rd_wen,
    output logic                      out_misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic [ISA_WIDTH-1:0] r_addr;
    logic [ISA_WIDTH-1:0] r_wdata;
    logic                 r_is_load;
    logic                 r_is_store;
    logic [2:0]           r_funct3;
    logic [REG_AW-1:0]    r_rd;
    logic                 r_rd_wen;
    logic [ISA_WIDTH-1:0] r_res;
    logic                 r_misalign;

    logic                 w_accept;
    logic                 w_in_mem;
    logic                 w_in_misalign;
    logic                 w_in_store_only;
    logic                 w_req_fire;
    logic                 w_resp_take;
    logic [ISA_WIDTH-1:0] w_shifted;
    logic [ISA_WIDTH-1:0] w_load_data;
    logic [3:0]           w_wstrb;
    logic [ISA_WIDTH-1:0] w_store_data;

    assign w_accept        = in_valid && (r_state == StIdle);
    assign w_in_mem        = in_is_load || in_is_store;
    // funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111 as word)
    assign w_in_misalign   = w_in_mem &&
                             (((in_funct3[1:0] == 2'b01) && in_alu_res[0]) ||
                              (in_funct3[1] && (in_alu_res[1:0] != 2'b00)));
    // A packet flagged as both load and store is handled as a load.
    assign w_in_store_only = in_is_store && !in_is_load;
    assign w_req_fire      = (r_state == StReq) && mem.mem_req_ready;
    // A response only counts once the request has been handed over.
    assign w_resp_take     = mem.mem_resp_valid && (w_req_fire || (r_state == StWait));
    assign w_shifted       = mem.mem_rdata >> {r_addr[1:0], 3'b000};

    // Load extraction and extension
    always_comb begin
        w_load_data = mem.mem_rdata;
        unique case (r_funct3[1:0])
            2'b00:   w_load_data = r_funct3[2] ? {{(ISA_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                               : {{(ISA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_funct3[2] ? {{(ISA_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                               : {{(ISA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = mem.mem_rdata;
        endcase
    end

    // Store lane replication and byte strobes
    always_comb begin
        w_wstrb      = 4'b1111;
        w_store_data = r_wdata;
        unique case (r_funct3[1:0])
            2'b00: begin
                w_wstrb      = 4'b0001 << r_addr[1:0];
                w_store_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb      = 4'b0011 << r_addr[1:0];
                w_store_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_wstrb      = 4'b1111;
                w_store_data = r_wdata;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (w_in_mem && !w_in_misalign) ? StReq : StDone;
                end
            end
            StReq: begin
                if (w_req_fire) begin
                    w_state_next = mem.mem_resp_valid ? StDone : StWait;
                end
            end
            StWait: begin
                if (mem.mem_resp_valid) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs; request fields come from latched state so they hold while stalled
    always_comb begin
        in_ready          = (r_state == StIdle);
        out_valid         = (r_state == StDone);
        mem.mem_req_valid = (r_state == StReq);
        mem.mem_wen       = (r_state == StReq) && r_is_store && !r_is_load;
        mem.mem_wstrb     = mem.mem_wen ? w_wstrb : 4'b0000;
        mem.mem_addr      = {r_addr[ISA_WIDTH-1:2], 2'b00};
        mem.mem_wdata     = w_store_data;
        out_res           = r_res;
        out_rd            = r_rd;
        out_rd_wen        = r_rd_wen;
        out_misalign      = r_misalign;
    end

    // Packet latch and writeback result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_rd       <= '0;
            r_rd_wen   <= 1'b0;
            r_res      <= '0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= in_alu_res;
            r_wdata    <= in_wdata;
            r_is_load  <= in_is_load;
            r_is_store <= in_is_store;
            r_funct3   <= in_funct3;
            r_rd       <= in_rd;
            r_rd_wen   <= in_rd_wen && !w_in_misalign && !w_in_store_only;
            r_res      <= in_alu_res;
            r_misalign <= w_in_misalign;
        end else if (w_resp_take && r_is_load) begin
            r_res      <= w_load_data;
        end
    end

endmodule

// File: doc/ysyx_23060124_lsu.md
Name: ysyx_23060124_lsu

Overview:
- Load/store unit directly downstream of the ALU in the EXU→LSU→WBU path.
- Takes the ALU result (effective address, or plain result for non-memory ops) plus store data and access type.
- Memory ops run through a single-outstanding req/resp memory port; the unit aligns and extends load data and forms store byte strobes.
- Delivers one writeback packet per instruction to the WBU under valid/ready handshake.

Parameters:
- ISA_WIDTH, 32, data/address width.
- REG_AW, 5, register index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EXU packet valid.
- in_ready  out  1  LSU can accept a packet.
- in_alu_res  in  ISA_WIDTH  ALU result / effective address.
- in_wdata  in  ISA_WIDTH  store source (rs2).
- in_is_load  in  1  packet is a load.
- in_is_store  in  1  packet is a store.
- in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_rd  in  REG_AW  destination register.
- in_rd_wen  in  1  destination write enable.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ISA_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_wen  out  1  1 = write.
- mem_wdata  out  ISA_WIDTH  lane-shifted store data.
- mem_wstrb  out  4  byte strobes.
- mem_resp_valid  in  1  response valid (single cycle).
- mem_rdata  in  ISA_WIDTH  read word.
- out_valid  out  1  writeback packet valid.
- out_ready  in  1  WBU accepts.
- out_res  out  ISA_WIDTH  value to write back.
- out_rd  out  REG_AW  destination register.
- out_rd_wen  out  1  write enable (0 for stores and faults).
- out_misalign  out  1  misaligned-access fault flag.

Behaviour:
- Reset (async, reset=1): state IDLE; in_ready=1; mem_req_valid=0; out_valid=0; out_res=0; out_rd=0; out_rd_wen=0; out_misalign=0; mem_wen=0; mem_wstrb=0.
- States: IDLE, REQ, WAIT, DONE.
- in_ready=1 only in IDLE.
- IDLE accepts a packet on in_valid && in_ready and latches all in_* fields.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]≠0, on a load or store.
- Non-memory packet: DONE next cycle with out_res=in_alu_res, out_rd_wen=in_rd_wen. Latency 1 cycle.
- Misaligned memory packet: DONE next cycle, out_misalign=1, out_rd_wen=0, out_res=in_alu_res, no memory request issued.
- Aligned memory packet: go to REQ.
- REQ: mem_req_valid=1 with stable addr/wen/wdata/wstrb until mem_req_ready. On the handshake go to WAIT. mem_resp_valid in the same cycle as the handshake is legal: then go straight to DONE.
- WAIT: on mem_resp_valid go to DONE and capture the result. A response arriving in REQ before the request handshake is ignored.
- Store formation:
  - B: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H: wstrb=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - W: wstrb=4'b1111, wdata unchanged.
  - Loads: wstrb=0, wen=0.
- Load extraction: shifted=rdata>>(8*addr[1:0]).
  - B: sign-extend shifted[7:0]. BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0]. HU: zero-extend shifted[15:0].
  - W: rdata as is.
  - funct3 values 011/110/111 are treated as W.
- Store completion: out_rd_wen=0, out_res=in_alu_res.
- DONE: out_valid=1 with outputs held stable until out_ready. On the handshake go to IDLE and clear out_valid.
  - Back-to-back throughput: one non-memory packet every 2 cycles (no DONE→accept bypass).
- Minimum memory-op latency: accept→DONE in 2 cycles, with ready and response both in the REQ cycle.
- Reset mid-operation: abandons any outstanding request. A late mem_resp_valid after reset is ignored (state IDLE).

Test Plan:
- Non-memory: alu_res=0x0000_1234, rd=5, wen=1 → out_valid one cycle after accept, out_res=0x1234, out_rd=5, no mem_req_valid.
- LB at 0x8000_0003, rdata=0x80FF_0011 → mem_addr=0x8000_0000, out_res=0xFFFF_FF80. The same with LBU → 0x0000_0080.
- SH at 0x8000_0102, wdata=0xDEAD_BEEF → mem_wdata=0xBEEF_BEEF, mem_wstrb=4'b1100, out_rd_wen=0.
- LW at 0x8000_0006 → no memory request, out_misalign=1, out_rd_wen=0, out_res=0x8000_0006.
- Back-pressure:
  - Hold mem_req_ready=0 for 3 cycles → address/strobes stable, in_ready=0.
  - Hold out_ready=0 for 4 cycles in DONE → outputs unchanged, next packet not accepted.
- Assert reset while in WAIT, then pulse mem_resp_valid → all outputs at reset values, no out_valid pulse, next packet accepted normally.
